// File: rtl/uart_receiver_if.sv
// Receive-side pin/bus bundle for uart_receiver: the serial line in and the
// decoded byte plus status strobes out.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_error;
  logic                 o_busy;

  modport master (
    output i_rx,
    input  o_data, o_valid, o_frame_error, o_busy
  );

  modport slave (
    input  i_rx,
    output o_data, o_valid, o_frame_error, o_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: 2-flop synchroniser, half-bit start qualification,
// centre sampling of data/stop bits, frame-error detection with break hold-off.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic            clk,
  input  logic            i_reset,
  uart_receiver_if.slave  rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_if.i_rx;
      rx_s_q    <= rx_meta_q;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // A start bit that is high again at its centre was only a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BITS_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign rx_if.o_data        = data_q;
  assign rx_if.o_valid       = valid_q;
  assign rx_if.o_frame_error = ferr_q;
  assign rx_if.o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised self-checking bench for uart_receiver: frames are generated on the
// line and each is expected to produce one strobe at a fixed latency.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int LAT = CPB / 2 + 9 * CPB + 3;

  logic clk = 1'b0;
  logic i_reset;
  always #5 clk = ~clk;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .rx_if  (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 1 = good byte, 2 = frame error
    logic [7:0]  data;
    int unsigned at;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.o_valid || bus.o_frame_error) begin
      check("valid_ferr_exclusive", 32'(bus.o_valid & bus.o_frame_error), 0);
      obs_q.push_back('{kind: (bus.o_valid ? 1 : 2), data: bus.o_data, at: cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc);
    logic [9:0] seq;
    seq = {stop, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      bus.i_rx = seq[c / CPB];
      tick(1);
    end
  endtask

  // Reference: a frame starting at cycle t yields its strobe at t + LAT;
  // a bad stop bit reports an error and leaves the byte register alone.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back('{kind: 1, data: b, at: cyc + LAT});
      last_good = b;
    end else begin
      exp_q.push_back('{kind: 2, data: last_good, at: cyc + LAT});
    end
    drive_frame(b, stop, 10 * CPB);
  endtask

  task automatic compare_events(input string tag);
    ev_t e;
    ev_t o;
    int  d;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing_event"}, 0, 1);
      end else begin
        o = obs_q.pop_front();
        d = int'(o.at) - int'(e.at);
        check({tag, "_kind"}, o.kind, e.kind);
        check({tag, "_data"}, o.data, e.data);
        if (d < -1 || d > 1)
          $display("latency off by %0d cycles at cycle %0d", d, o.at);
        check({tag, "_latency_ok"}, 32'(d >= -1 && d <= 1), 1);
      end
    end
    check({tag, "_extra_events"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         gap;

    // Reset with the line toggling
    i_reset  = 1'b1;
    bus.i_rx = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      bus.i_rx = i[0];
      tick(1);
      check("rst_data", bus.o_data, 0);
      check("rst_valid", bus.o_valid, 0);
      check("rst_ferr", bus.o_frame_error, 0);
      check("rst_busy", bus.o_busy, 0);
    end
    i_reset  = 1'b0;
    bus.i_rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("post_rst_busy", bus.o_busy, 0);
    end
    compare_events("post_rst");

    // Single frame
    send_frame(8'hF0, 1'b1);
    tick(4);
    compare_events("single_f0");

    // Back-to-back, no idle gap
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    compare_events("b2b");

    // Short low glitch
    bus.i_rx = 1'b0;
    tick(4);
    bus.i_rx = 1'b1;
    tick(30);
    check("glitch_busy", bus.o_busy, 0);
    compare_events("glitch");
    send_frame(8'h3C, 1'b1);
    tick(4);
    compare_events("after_glitch");

    // Framing error followed by a held-low line
    send_frame(8'h81, 1'b0);
    tick(100);
    check("break_busy", bus.o_busy, 1);
    check("break_data_hold", bus.o_data, last_good);
    bus.i_rx = 1'b1;
    tick(4);
    check("break_release_busy", bus.o_busy, 0);
    compare_events("frame_err");
    send_frame(8'h42, 1'b1);
    tick(4);
    compare_events("after_ferr");

    // Reset during data bit 3
    drive_frame(8'hAA, 1'b1, 4 * CPB + CPB / 2);
    i_reset  = 1'b1;
    bus.i_rx = 1'b1;
    tick(2);
    last_good = 8'h00;
    check("midrst_data", bus.o_data, 0);
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_ferr", bus.o_frame_error, 0);
    check("midrst_busy", bus.o_busy, 0);
    i_reset = 1'b0;
    tick(1);
    check("midrst_after_valid", bus.o_valid, 0);
    tick(CPB * 12);
    compare_events("mid_reset");
    send_frame(8'h99, 1'b1);
    tick(4);
    compare_events("after_midrst");

    // Random bytes with random idle gaps (including none)
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      gap = $urandom_range(0, 20);
      if (gap > 0) begin
        bus.i_rx = 1'b1;
        tick(gap);
      end
    end
    tick(4);
    compare_events("random");
    check("final_data", bus.o_data, last_good);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It is the receive-side counterpart of uart_transmitter and decodes 8N1 frames (1 start, DATA_BITS data LSB-first, 1 stop) from the asynchronous i_rx line. Each good byte appears on o_data with a one-cycle o_valid strobe. It sits at the pin boundary feeding the command/data path and shares the transmitter's clock and baud parameterisation.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; must be ≥4 and even
DATA_BITS, 8, data bits per frame; range 5..8

Ports:
clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_rx  input  1  asynchronous serial line; idles high
o_data  output  DATA_BITS  last correctly received byte; holds until the next good frame
o_valid  output  1  one-cycle pulse when o_data is updated
o_frame_error  output  1  one-cycle pulse when the stop bit is sampled low
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_reset high at a clk edge): state=IDLE, o_data=0, o_valid=0, o_frame_error=0, o_busy=0, bit/clk counters=0, synchroniser flops=1. Reset overrides everything, including mid-frame; the partial byte is discarded.
- Input synchroniser: 2 flops on i_rx, reset to 1. rx_s is the second flop. All decisions use rx_s only, so there is a fixed 2-cycle input latency.
- Clock counter clk_cnt: width clog2(CLKS_PER_BIT). Cleared on every state entry. bit_cnt: width clog2(DATA_BITS+1).
- States:
  - IDLE: if rx_s==0, go to START.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample rx_s. If 0, go to DATA with clk_cnt cleared. If 1, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: every CLKS_PER_BIT cycles (at clk_cnt==CLKS_PER_BIT-1) sample rx_s into a shift register, LSB first (shift right, new bit at MSB), and increment bit_cnt. After DATA_BITS samples, go to STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1 sample rx_s.
    - If 1: o_data is loaded from the shift register, o_valid pulses for exactly 1 cycle, go to IDLE.
    - If 0: o_frame_error pulses for 1 cycle, o_data is unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line therefore yields exactly one frame error and no re-triggering.
- Sampling point: each data and stop bit is sampled CLKS_PER_BIT cycles after the previous sample, which is the nominal bit centre.
- Latency: o_valid asserts (CLKS_PER_BIT/2) + (DATA_BITS+1)*CLKS_PER_BIT + 3 cycles after the first clk edge at which i_rx is seen low. The bench allows ±1 cycle.
- o_valid and o_frame_error are never high in the same cycle. Neither is high during reset or in the cycle after reset.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted. The transition STOP→IDLE→START costs at most 2 cycles, which the half-bit stop margin absorbs.
- o_busy is combinational from state (state != IDLE).
- i_rx changes during DATA do not affect the timing; only the centre samples matter.

Test Plan:
- Reset: hold i_reset=1 for 5 cycles with i_rx toggling → o_data=0x00, o_valid=0, o_frame_error=0, o_busy=0 throughout. No activity for 20 cycles after release with i_rx=1.
- Single frame, CLKS_PER_BIT=16: send 0xF0 (line sequence 0,0,0,0,0,1,1,1,1,1) → exactly one o_valid pulse, o_data=0xF0, at 155±1 cycles after i_rx falls. o_frame_error stays 0.
- Back-to-back: send 0x55, 0xA3, 0x00, 0xFF with no idle gap → four o_valid pulses carrying the data in order, spaced 160±1 cycles apart.
- Glitch: drive i_rx low for 4 cycles then high → state returns to IDLE, no o_valid or o_frame_error. A following 0x3C frame is received correctly.
- Framing error: send 0x81 with the stop bit forced 0, keep the line low for 100 cycles, then release → one o_frame_error pulse, o_data keeps its previous value, o_busy stays high until the line goes high. The next 0x42 frame is received correctly.
- Reset mid-frame: assert i_reset during data bit 3 of 0xAA → no o_valid, outputs return to reset values. A following 0x99 frame is received as 0x99.
